// File: rtl/inst_loader.sv
// rtl/inst_loader.sv - boot image byte stream to instruction memory writer (optional checksum: INST_LOADER_CSUM_EN)
module inst_loader #(
   parameter int DEPTH = 1001,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [7:0]       rx_data,
   input  logic             rx_valid,
   output logic             rx_ready,
   output logic             mem_we,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   output logic             hold_core,
   output logic             done,
   output logic             error,
   output logic [CNT_W-1:0] words_loaded
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] LEN_LO = 3'd1;
   localparam logic [2:0] LEN_HI = 3'd2;
   localparam logic [2:0] DATA   = 3'd3;
   localparam logic [2:0] FIN    = 3'd4;   // final word being written, done follows
   localparam logic [2:0] CSUM   = 3'd5;
   localparam logic [2:0] DONE   = 3'd6;
   localparam logic [2:0] ERR    = 3'd7;

   logic [2:0]       state, state_nxt;
   logic [CNT_W-1:0] length, len_new, word_cnt, depth_c;
   logic [1:0]       byte_cnt;
   logic [23:0]      shift_reg;
   logic             accept, start_take, last_word;
`ifdef INST_LOADER_CSUM_EN
   logic [7:0]       csum;
`endif

   assign accept     = rx_valid && rx_ready;
   assign start_take = start && (state == IDLE || state == DONE || state == ERR);
   assign depth_c    = CNT_W'(DEPTH);
   assign len_new    = CNT_W'({rx_data, length[7:0]});
   assign last_word  = (word_cnt == length - CNT_W'(1));

   // Next-state decode; the session only advances on accepted bytes
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:   if (start) state_nxt = LEN_LO;
         LEN_LO: if (accept) state_nxt = LEN_HI;
         LEN_HI: if (accept) begin
`ifdef INST_LOADER_CSUM_EN
            if (len_new == '0)          state_nxt = CSUM;
`else
            if (len_new == '0)          state_nxt = DONE;
`endif
            else if (len_new > depth_c) state_nxt = ERR;
            else                        state_nxt = DATA;
         end
         DATA: if (accept && byte_cnt == 2'd3 && last_word) begin
`ifdef INST_LOADER_CSUM_EN
            state_nxt = CSUM;
`else
            state_nxt = FIN;
`endif
         end
         FIN:  state_nxt = DONE;
`ifdef INST_LOADER_CSUM_EN
         CSUM: if (accept) state_nxt = ((csum ^ rx_data) == 8'h00) ? DONE : ERR;
`endif
         DONE:    if (start) state_nxt = LEN_LO;
         ERR:     if (start) state_nxt = LEN_LO;
         default: state_nxt = IDLE;
      endcase
   end

   // State register and status outputs, registered from the next state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         rx_ready  <= 1'b0;
         hold_core <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
      end else begin
         state     <= state_nxt;
`ifdef INST_LOADER_CSUM_EN
         rx_ready  <= (state_nxt == LEN_LO) || (state_nxt == LEN_HI) ||
                      (state_nxt == DATA) || (state_nxt == CSUM);
         hold_core <= (state_nxt == LEN_LO) || (state_nxt == LEN_HI) ||
                      (state_nxt == DATA) || (state_nxt == CSUM) || (state_nxt == FIN);
`else
         rx_ready  <= (state_nxt == LEN_LO) || (state_nxt == LEN_HI) ||
                      (state_nxt == DATA);
         hold_core <= (state_nxt == LEN_LO) || (state_nxt == LEN_HI) ||
                      (state_nxt == DATA) || (state_nxt == FIN);
`endif
         done      <= (state_nxt == DONE);
         error     <= (state_nxt == ERR);
      end
   end

   // Header capture, little-endian word assembly and memory write strobe
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         length       <= '0;
         word_cnt     <= '0;
         byte_cnt     <= 2'd0;
         shift_reg    <= 24'd0;
         mem_we       <= 1'b0;
         mem_addr     <= 32'd0;
         mem_wdata    <= 32'd0;
         words_loaded <= '0;
`ifdef INST_LOADER_CSUM_EN
         csum         <= 8'h00;
`endif
      end else begin
         mem_we <= 1'b0;
         if (start_take) begin
            word_cnt     <= '0;
            byte_cnt     <= 2'd0;
            shift_reg    <= 24'd0;
            words_loaded <= '0;
`ifdef INST_LOADER_CSUM_EN
            csum         <= 8'h00;
`endif
         end
         if (accept && state == LEN_LO) length[7:0] <= rx_data;
         if (accept && state == LEN_HI) length <= len_new;
         if (accept && state == DATA) begin
`ifdef INST_LOADER_CSUM_EN
            csum <= csum ^ rx_data;
`endif
            if (byte_cnt == 2'd3) begin
               mem_we       <= 1'b1;
               mem_addr     <= {{(32-CNT_W){1'b0}}, word_cnt};
               mem_wdata    <= {rx_data, shift_reg};
               words_loaded <= words_loaded + CNT_W'(1);
               word_cnt     <= word_cnt + CNT_W'(1);
               byte_cnt     <= 2'd0;
            end else begin
               shift_reg <= {rx_data, shift_reg[23:8]};
               byte_cnt  <= byte_cnt + 2'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_inst_loader.sv
// tb/tb_inst_loader.sv - scoreboard bench for inst_loader
module tb_inst_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        hold_core;
   logic        done;
   logic        error;
   logic [15:0] words_loaded;

   int checks = 0;
   int errors = 0;
   logic [63:0] exp_q[$];

   inst_loader #(.DEPTH(1001), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .start(start),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .hold_core(hold_core), .done(done), .error(error),
      .words_loaded(words_loaded)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // scoreboard: every write strobe must match the oldest expected write
   always @(negedge clk) begin
      if (!rst && mem_we) begin
         if (exp_q.size() == 0) check("unexpected_we", {32'd0, mem_addr}, 64'hffff_ffff_ffff_ffff);
         else check("write", {mem_addr, mem_wdata}, exp_q.pop_front());
      end
   end

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      logic acc;
      int   n;
      rx_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
      rx_valid = 1'b1;
      rx_data  = b;
      n = 0;
      do begin
         acc = rx_ready;
         @(posedge clk); #1;
         n++;
      end while (!acc && n < 200);
      if (!acc) check("accept_timeout", 64'd0, 64'd1);
      rx_valid = 1'b0;
   endtask

   task automatic load_image(input logic [31:0] img[$], input int gap);
      logic [7:0]  x;
      logic [15:0] len;
      logic [31:0] w;
      x = 8'h00;
      len = 16'(img.size());
      pulse_start();
      check("hold_after_start", {63'd0, hold_core}, 64'd1);
      send_byte(len[7:0], gap);
      send_byte(len[15:8], gap);
      for (int i = 0; i < img.size(); i++) begin
         w = img[i];
         exp_q.push_back({32'(i), w});
         for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8], gap);
            x = x ^ w[8*k +: 8];
         end
      end
      check("we_latency", {63'd0, mem_we}, 64'd1);
`ifdef INST_LOADER_CSUM_EN
      send_byte(x, gap);
`else
      check("done_not_early", {63'd0, done}, 64'd0);
      @(posedge clk); #1;
`endif
      check("done", {63'd0, done}, 64'd1);
      check("words_loaded", {48'd0, words_loaded}, {32'd0, 32'(img.size())});
      check("hold_released", {63'd0, hold_core}, 64'd0);
      check("no_error", {63'd0, error}, 64'd0);
      check("sb_drained", 64'(exp_q.size()), 64'd0);
   endtask

   logic [31:0] small_img[$];
   logic [31:0] big_img[$];

   initial begin
      rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
      small_img = '{32'h00500013, 32'h00100093};
      repeat (3) @(posedge clk); #1;
      check("reset_outputs",
            {rx_ready, mem_we, hold_core, done, error, words_loaded, mem_addr[7:0], 32'd0},
            64'd0);
      check("reset_wdata", {32'd0, mem_wdata}, 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("idle_ready", {63'd0, rx_ready}, 64'd0);

      // normal load with continuous valid
      load_image(small_img, 0);

      // zero length
      pulse_start();
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
`ifdef INST_LOADER_CSUM_EN
      check("zero_len_wait_csum", {63'd0, done}, 64'd0);
      send_byte(8'h00, 0);
`endif
      check("zero_len_done", {63'd0, done}, 64'd1);
      check("zero_len_words", {48'd0, words_loaded}, 64'd0);

      // length == DEPTH is accepted; start in DATA is ignored
      pulse_start();
      send_byte(8'hE9, 0);
      send_byte(8'h03, 0);
      check("depth_len_ok", {62'd0, error, rx_ready}, 64'd1);
      pulse_start();
      check("start_ignored", {62'd0, hold_core, rx_ready}, 64'd3);
      rst = 1'b1; #2; rst = 1'b0;
      @(posedge clk); #1;

      // length == DEPTH + 1 is rejected
      pulse_start();
      send_byte(8'hEA, 0);
      send_byte(8'h03, 0);
      check("oversize_err", {61'd0, error, rx_ready, hold_core}, 64'd4);
      repeat (3) @(posedge clk); #1;
      check("oversize_done", {63'd0, done}, 64'd0);

      // restart from ERR with backpressure gaps
      load_image(small_img, 2);

      // full-depth load, last write at DEPTH-1
      for (int i = 0; i < 1001; i++) big_img.push_back($urandom);
      load_image(big_img, 0);
      check("last_addr", {32'd0, mem_addr}, 64'd1000);

      // reset mid-load after the 2nd byte of word 1
      pulse_start();
      send_byte(8'h02, 0);
      send_byte(8'h00, 0);
      exp_q.push_back({32'd0, 32'hdeadbeef});
      send_byte(8'hef, 0); send_byte(8'hbe, 0); send_byte(8'had, 0); send_byte(8'hde, 0);
      send_byte(8'h11, 0); send_byte(8'h22, 0);
      #2 rst = 1'b1;
      #1;
      check("async_reset",
            {rx_ready, mem_we, hold_core, done, error, words_loaded, mem_addr[7:0], 32'd0},
            64'd0);
      check("async_reset_wdata", {32'd0, mem_wdata}, 64'd0);
      check("sb_word0", 64'(exp_q.size()), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      load_image(small_img, 1);

`ifdef INST_LOADER_CSUM_EN
      // bad checksum aborts after the writes
      pulse_start();
      send_byte(8'h02, 0); send_byte(8'h00, 0);
      exp_q.push_back({32'd0, 32'h00500013});
      exp_q.push_back({32'd1, 32'h00100093});
      send_byte(8'h13, 0); send_byte(8'h00, 0); send_byte(8'h50, 0); send_byte(8'h00, 0);
      send_byte(8'h93, 0); send_byte(8'h00, 0); send_byte(8'h10, 0); send_byte(8'h00, 0);
      send_byte(8'h84, 0);
      check("bad_csum", {62'd0, error, done}, 64'd2);
`endif

      repeat (3) @(posedge clk); #1;
      check("sb_final", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
